// File: rtl/bnn_pool_pkg.sv
// Shared types and sizing helpers for the BNN pooling window sequencer.
package bnn_pool_pkg;

  // Sequencer states: idle between frames, streaming pixels, holding a window.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Counter width for an index range 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of pooling windows along one image side.
  function automatic int win_per_side(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  localparam int DEF_IMG_DIM      = 28;
  localparam int DEF_KERNEL_DIM   = 2;
  localparam int DEF_STRIDE       = 2;
  localparam int DEF_CNT_W        = cnt_width(DEF_IMG_DIM);
  localparam int DEF_WIN_PER_SIDE = win_per_side(DEF_IMG_DIM, DEF_KERNEL_DIM, DEF_STRIDE);

endpackage

// File: rtl/pool_pos_counter.sv
// Raster position tracker for the pooling line buffer.
// Keeps row/column counters plus stride-phase counters so window alignment
// is decided without any division; also tracks the output-grid window index.
module pool_pos_counter
  import bnn_pool_pkg::*;
#(
  parameter int IMG_DIM    = DEF_IMG_DIM,
  parameter int KERNEL_DIM = DEF_KERNEL_DIM,
  parameter int STRIDE     = DEF_STRIDE,
  localparam int CW        = cnt_width(IMG_DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_advance,
  output logic          o_win_complete,
  output logic          o_last_pixel,
  output logic [CW-1:0] o_win_row,
  output logic [CW-1:0] o_win_col
);

  localparam int PW = cnt_width(STRIDE);
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_DIM - 1);
  localparam logic [CW-1:0] K_M1     = CW'(KERNEL_DIM - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'(STRIDE - 1);

  logic [CW-1:0] r_col, r_row, r_win_col, r_win_row;
  logic [PW-1:0] r_col_ph, r_row_ph;
  logic [CW-1:0] w_col_nxt, w_row_nxt, w_win_col_nxt, w_win_row_nxt;
  logic [PW-1:0] w_col_ph_nxt, w_row_ph_nxt;
  logic          w_col_wrap;

  assign w_col_wrap = (r_col == LAST_IDX);

  // Next column position, phase and window index; phase restarts where the first window ends.
  always_comb begin
    w_col_nxt     = r_col;
    w_col_ph_nxt  = r_col_ph;
    w_win_col_nxt = r_win_col;
    if (i_advance) begin
      if (w_col_wrap) begin
        w_col_nxt     = '0;
        w_col_ph_nxt  = '0;
        w_win_col_nxt = '0;
      end else begin
        w_col_nxt = r_col + CW'(1);
        if (r_col < K_M1) begin
          w_col_ph_nxt  = '0;
          w_win_col_nxt = '0;
        end else if (r_col_ph == PH_MAX) begin
          w_col_ph_nxt  = '0;
          w_win_col_nxt = r_win_col + CW'(1);
        end else begin
          w_col_ph_nxt  = r_col_ph + PW'(1);
          w_win_col_nxt = r_win_col;
        end
      end
    end else begin
      w_col_nxt = r_col;
    end
  end

  // Next row position, phase and window index; rows only move on a column wrap.
  always_comb begin
    w_row_nxt     = r_row;
    w_row_ph_nxt  = r_row_ph;
    w_win_row_nxt = r_win_row;
    if (i_advance && w_col_wrap) begin
      if (r_row == LAST_IDX) begin
        w_row_nxt     = '0;
        w_row_ph_nxt  = '0;
        w_win_row_nxt = '0;
      end else begin
        w_row_nxt = r_row + CW'(1);
        if (r_row < K_M1) begin
          w_row_ph_nxt  = '0;
          w_win_row_nxt = '0;
        end else if (r_row_ph == PH_MAX) begin
          w_row_ph_nxt  = '0;
          w_win_row_nxt = r_win_row + CW'(1);
        end else begin
          w_row_ph_nxt  = r_row_ph + PW'(1);
          w_win_row_nxt = r_win_row;
        end
      end
    end else begin
      w_row_nxt = r_row;
    end
  end

  // Position state registers; reset restarts the raster at pixel (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_col_ph  <= '0;
      r_row_ph  <= '0;
      r_win_col <= '0;
      r_win_row <= '0;
    end else begin
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_col_ph  <= w_col_ph_nxt;
      r_row_ph  <= w_row_ph_nxt;
      r_win_col <= w_win_col_nxt;
      r_win_row <= w_win_row_nxt;
    end
  end

  // The current pixel closes a window when both axes sit on a stride boundary past the kernel edge.
  assign o_win_complete = (r_row >= K_M1) && (r_col >= K_M1) &&
                          (r_row_ph == '0) && (r_col_ph == '0);
  assign o_last_pixel   = (r_row == LAST_IDX) && w_col_wrap;
  assign o_win_row      = r_win_row;
  assign o_win_col      = r_win_col;

endmodule

// File: rtl/pool_window_ctrl.sv
// Pooling window sequencer: accepts a raster pixel stream, drives the line
// buffer write enable and presents each completed, stride-aligned window
// to the downstream pooling stage, stalling the stream until it is taken.
// Optional build macro POOL_WINDOW_CTRL_STATS_EN adds o_stall_cycles, a
// saturating count of cycles spent holding a window that is not yet taken.
module pool_window_ctrl
  import bnn_pool_pkg::*;
#(
  parameter int IMG_DIM    = DEF_IMG_DIM,
  parameter int KERNEL_DIM = DEF_KERNEL_DIM,
  parameter int STRIDE     = DEF_STRIDE,
  localparam int CW        = cnt_width(IMG_DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_write_enable,
  output logic          o_window_valid,
  input  logic          i_window_ready,
  output logic [CW-1:0] o_win_row,
  output logic [CW-1:0] o_win_col,
  output logic          o_busy,
`ifdef POOL_WINDOW_CTRL_STATS_EN
  output logic [31:0]   o_stall_cycles,
`endif
  output logic          o_frame_done
);

  if ((KERNEL_DIM > IMG_DIM) || (STRIDE == 0) || (KERNEL_DIM < 1)) begin : g_bad_cfg
    $error("pool_window_ctrl: need 1 <= KERNEL_DIM <= IMG_DIM and STRIDE > 0");
  end

  state_e        r_state, w_state_nxt;
  logic          w_accept, w_win_complete, w_last_pixel;
  logic          w_done_nxt, w_load_win;
  logic          r_hold_last, r_frame_done;
  logic [CW-1:0] w_pos_win_row, w_pos_win_col, r_win_row, r_win_col;

  pool_pos_counter #(
    .IMG_DIM   (IMG_DIM),
    .KERNEL_DIM(KERNEL_DIM),
    .STRIDE    (STRIDE)
  ) u_pos (
    .clk           (clk),
    .rst           (rst),
    .i_advance     (w_accept),
    .o_win_complete(w_win_complete),
    .o_last_pixel  (w_last_pixel),
    .o_win_row     (w_pos_win_row),
    .o_win_col     (w_pos_win_col)
  );

  assign o_ready        = (r_state == ST_RUN);
  assign w_accept       = i_valid && o_ready;
  assign o_write_enable = w_accept;
  assign o_window_valid = (r_state == ST_HOLD);
  assign o_busy         = (r_state != ST_IDLE);
  assign o_win_row      = r_win_row;
  assign o_win_col      = r_win_col;
  assign o_frame_done   = r_frame_done;

  // Next-state, frame-done and window-capture decisions for the handshake FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load_win  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && w_win_complete) begin
          w_state_nxt = ST_HOLD;
          w_load_win  = 1'b1;
        end else if (w_accept && w_last_pixel) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (i_window_ready && r_hold_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (i_window_ready) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, done pulse and held-window registers; window index is captured with the completing write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
      r_hold_last  <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done_nxt;
      if (w_load_win) begin
        r_hold_last <= w_last_pixel;
        r_win_row   <= w_pos_win_row;
        r_win_col   <= w_pos_win_col;
      end
    end
  end

`ifdef POOL_WINDOW_CTRL_STATS_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of held cycles the consumer left waiting; restarts with each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_stall_cycles <= 32'd0;
    end else if ((r_state == ST_HOLD) && !i_window_ready &&
                 (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
